cancel_accumulator: RTL and testbench

Parametrised per-client cancellation accumulator for the downstream path: keeps a running total per client in an internal synchronous-read RAM and applies ADD, CLEAR or QUERY requests through a 2-stage read-modify-write pipeline. Back-to-back requests to the same client are forwarded internally. A hardware init sweep zeroes the table after reset. Each request produces exactly one result beat toward downstream reporting logic.

---
 rtl/cancel_acc_pkg.sv | 33 +++
 rtl/cancel_acc_ram.sv | 35 +++
 rtl/cancel_accumulator.sv | 187 ++++++++++++++++++
 tb/tb_cancel_accumulator.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cancel_acc_pkg.sv
// cancel_acc_pkg
//   Shared types and default widths for the cancellation accumulator.
//   - op_t    : request operation (ADD, CLEAR, QUERY)
//   - state_t : controller state (ST_INIT sweep, ST_RUN)
//   - decode_op() maps the raw 2-bit request opcode onto op_t
//   Optional feature macro used by the design: CANCEL_ACC_SAT_EN.
package cancel_acc_pkg;

   localparam int DEF_CLIENT_W = 5;
   localparam int DEF_AMOUNT_W = 32;
   localparam int DEF_TOTAL_W  = 32;

   typedef enum logic [1:0] {
      OP_ADD   = 2'b00,
      OP_CLEAR = 2'b01,
      OP_QUERY = 2'b10
   } op_t;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Opcode 2'b11 is reserved and behaves as a QUERY.
   function automatic op_t decode_op(input logic [1:0] raw);
      case (raw)
         2'b00:   return OP_ADD;
         2'b01:   return OP_CLEAR;
         default: return OP_QUERY;
      endcase
   endfunction

endpackage

// File: rtl/cancel_acc_ram.sv
// cancel_acc_ram
//   Simple dual-port table, DEPTH = 2**ADDR_W words of DATA_W bits.
//   One write port and one read port on the same clock. The read is
//   registered (data appears the cycle after raddr is sampled) and returns
//   the pre-write contents when raddr == waddr on the same edge.
//   No reset: the owner zeroes the contents with a write sweep.
//   Ports:
//     clk            clock
//     we/waddr/wdata write port
//     raddr          read address, sampled every edge
//     rdata          read data, valid one cycle after raddr
module cancel_acc_ram #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // Read and write in the same block with non-blocking assignments:
   // the read observes the old word on an address collision.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/cancel_accumulator.sv
// cancel_accumulator
//   Per-client running totals kept in a synchronous-read table, updated by
//   ADD / CLEAR / QUERY requests through a 2-stage read-modify-write pipeline.
//   After reset an init sweep zeroes every entry, then the unit accepts one
//   request per cycle forever. Each accepted request yields one result beat.
//
//   Handshake: a request transfers on a rising edge where in_valid && in_ready.
//   in_ready depends only on the controller state (low during the sweep, high
//   afterwards). out_valid is a one-cycle strobe with no backpressure; the
//   result of a request accepted at edge N is presented after edge N+1.
//
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     in_valid/in_ready   request handshake
//     in_client_id        target client
//     in_op               00 ADD, 01 CLEAR, 10/11 QUERY
//     in_amount           addend for ADD
//     out_valid           result strobe
//     out_client_id       client of the result
//     out_total           ADD: new total; CLEAR/QUERY: total before the op
//     out_sat             ADD saturated on this beat
//     dbg_state           controller state, for observation only
//
//   Optional feature: define CANCEL_ACC_SAT_EN to saturate ADD at the maximum
//   total instead of wrapping; when undefined out_sat is always 0.
module cancel_accumulator
   import cancel_acc_pkg::*;
#(
   parameter int CLIENT_W = DEF_CLIENT_W,
   parameter int AMOUNT_W = DEF_AMOUNT_W,
   parameter int TOTAL_W  = DEF_TOTAL_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [CLIENT_W-1:0] in_client_id,
   input  logic [1:0]          in_op,
   input  logic [AMOUNT_W-1:0] in_amount,
   output logic                out_valid,
   output logic [CLIENT_W-1:0] out_client_id,
   output logic [TOTAL_W-1:0]  out_total,
   output logic                out_sat,
   output state_t              dbg_state
);

   // ---------------------------------------------------------------- control
   state_t              state_q, state_d;
   logic [CLIENT_W-1:0] init_ptr;
   logic                init_we;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_INIT;
         init_ptr <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_INIT) begin
            init_ptr <= init_ptr + 1'b1;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      init_we  = 1'b0;
      case (state_q)
         ST_INIT: begin
            init_we = 1'b1;
            if (&init_ptr) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            in_ready = 1'b1;
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   assign dbg_state = state_q;

   // --------------------------------------------------------------- stage 0
   logic                accept;
   logic                s1_valid;
   logic [CLIENT_W-1:0] s1_client;
   op_t                 s1_op;
   logic [AMOUNT_W-1:0] s1_amount;
   logic                s1_fwd;
   logic [TOTAL_W-1:0]  fwd_total;

   assign accept = in_valid && in_ready;

   // s1_fwd marks that the request ahead of this one targets the same client
   // and writes on this very edge, so the RAM read issued now is stale.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_client <= '0;
         s1_op     <= OP_QUERY;
         s1_amount <= '0;
         s1_fwd    <= 1'b0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_client <= in_client_id;
            s1_op     <= decode_op(in_op);
            s1_amount <= in_amount;
            s1_fwd    <= s1_valid && (s1_client == in_client_id);
         end
      end
   end

   // ------------------------------------------------------------------ table
   logic                ram_we;
   logic [CLIENT_W-1:0] ram_waddr;
   logic [TOTAL_W-1:0]  ram_wdata;
   logic [TOTAL_W-1:0]  ram_rdata;
   logic [TOTAL_W-1:0]  new_total;

   // Writes are gated by rst_n so nothing lands in the table while reset is held.
   assign ram_we    = rst_n && (init_we || (s1_valid && s1_op != OP_QUERY));
   assign ram_waddr = init_we ? init_ptr : s1_client;
   assign ram_wdata = init_we ? '0 : new_total;

   cancel_acc_ram #(
      .ADDR_W (CLIENT_W),
      .DATA_W (TOTAL_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .raddr (in_client_id),
      .rdata (ram_rdata)
   );

   // --------------------------------------------------------------- stage 1
   logic [TOTAL_W-1:0] old_total;
   logic [TOTAL_W-1:0] add_total;
   logic               add_sat;

   assign old_total = s1_fwd ? fwd_total : ram_rdata;

`ifdef CANCEL_ACC_SAT_EN
   logic [TOTAL_W:0] sum_wide;
   assign sum_wide  = {1'b0, old_total} + (TOTAL_W+1)'(s1_amount);
   assign add_sat   = sum_wide[TOTAL_W];
   assign add_total = add_sat ? {TOTAL_W{1'b1}} : sum_wide[TOTAL_W-1:0];
`else
   assign add_sat   = 1'b0;
   assign add_total = old_total + TOTAL_W'(s1_amount);
`endif

   always_comb begin
      new_total = old_total;
      case (s1_op)
         OP_ADD:   new_total = add_total;
         OP_CLEAR: new_total = '0;
         default:  new_total = old_total;
      endcase
   end

   // fwd_total holds the value the table holds for s1_client after this edge,
   // which differs from out_total for CLEAR (reported old, stored zero).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fwd_total     <= '0;
         out_valid     <= 1'b0;
         out_client_id <= '0;
         out_total     <= '0;
         out_sat       <= 1'b0;
      end else begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            fwd_total     <= new_total;
            out_client_id <= s1_client;
            out_total     <= (s1_op == OP_ADD) ? new_total : old_total;
            out_sat       <= (s1_op == OP_ADD) && add_sat;
         end
      end
   end

endmodule

// File: tb/tb_cancel_accumulator.sv
// tb_cancel_accumulator
//   Directed steps followed by random traffic; every result beat is checked
//   against a per-client array model updated in request order.
module tb_cancel_accumulator;
   import cancel_acc_pkg::*;

   localparam int CW = 5;
   localparam int NC = 32;

   // ---------------------------------------------------- clock / reset block
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [CW-1:0] in_client_id = '0;
   logic [1:0]    in_op = 2'b00;
   logic [31:0]   in_amount = '0;
   logic          out_valid;
   logic [CW-1:0] out_client_id;
   logic [31:0]   out_total;
   logic          out_sat;
   state_t        dbg_state;

   cancel_accumulator dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_client_id  (in_client_id),
      .in_op         (in_op),
      .in_amount     (in_amount),
      .out_valid     (out_valid),
      .out_client_id (out_client_id),
      .out_total     (out_total),
      .out_sat       (out_sat),
      .dbg_state     (dbg_state)
   );

   // -------------------------------------------------------------- scoreboard
   typedef struct {
      logic [CW-1:0] client;
      logic [31:0]   total;
      logic          sat;
      int            due;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] model [NC];
   int          n_cmp = 0;
   int          n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      assert (got === want)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   // A result is due on the negedge after the edge following its accept edge.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (exp_q.size() != 0 && cyc >= exp_q[0].due) begin
            e = exp_q.pop_front();
            check("out_valid_due", {31'd0, out_valid}, 32'd1);
            if (out_valid) begin
               check("out_client", {27'd0, out_client_id}, {27'd0, e.client});
               check("out_total", out_total, e.total);
               check("out_sat", {31'd0, out_sat}, {31'd0, e.sat});
            end
         end else begin
            check("out_valid_spurious", {31'd0, out_valid}, 32'd0);
         end
      end
   end

   // -------------------------------------------------------------- model
   task automatic model_apply(input logic [CW-1:0] c, input logic [1:0] op,
                              input logic [31:0] amt);
      exp_t e;
      logic [32:0] s;
      e.client = c;
      e.due    = cyc + 2;
      e.sat    = 1'b0;
      case (op)
         2'b00: begin
            s = {1'b0, model[c]} + {1'b0, amt};
`ifdef CANCEL_ACC_SAT_EN
            if (s[32]) begin
               model[c] = 32'hFFFF_FFFF;
               e.sat    = 1'b1;
            end else begin
               model[c] = s[31:0];
            end
`else
            model[c] = s[31:0];
`endif
            e.total = model[c];
         end
         2'b01: begin
            e.total  = model[c];
            model[c] = 32'd0;
         end
         default: e.total = model[c];
      endcase
      exp_q.push_back(e);
   endtask

   // ------------------------------------------------------------ driver tasks
   // Called at a negedge; returns at the next negedge.
   task automatic send(input logic [CW-1:0] c, input logic [1:0] op, input logic [31:0] amt);
      logic acc;
      in_valid     = 1'b1;
      in_client_id = c;
      in_op        = op;
      in_amount    = amt;
      acc          = in_ready;
      @(posedge clk);
      if (acc) model_apply(c, op, amt);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Called at the negedge where rst_n was just released.
   task automatic init_wait();
      for (int i = 0; i < NC - 1; i++) begin
         @(posedge clk);
         #1;
         check("ready_low_init", {31'd0, in_ready}, 32'd0);
      end
      @(posedge clk);
      #1;
      check("ready_rise", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
   endtask

   task automatic query_all();
      for (int c = 0; c < NC; c++) send(CW'(c), 2'b10, 32'd0);
      idle(3);
   endtask

   // ----------------------------------------------------------------- stimulus
   initial begin
      for (int c = 0; c < NC; c++) model[c] = 32'd0;

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_client", {27'd0, out_client_id}, 32'd0);
      check("rst_out_total", out_total, 32'd0);
      check("rst_out_sat", {31'd0, out_sat}, 32'd0);
      check("rst_state", {31'd0, dbg_state}, {31'd0, ST_INIT});

      // Requests offered during the sweep must be ignored.
      rst_n        = 1'b1;
      in_valid     = 1'b1;
      in_client_id = 5'd3;
      in_op        = 2'b00;
      in_amount    = 32'd99;
      init_wait();
      in_valid = 1'b0;
      check("run_state", {31'd0, dbg_state}, {31'd0, ST_RUN});
      query_all();

      // Back-to-back on one client, then a later query.
      send(5'd3, 2'b00, 32'd10);
      send(5'd3, 2'b00, 32'd5);
      idle(2);
      send(5'd3, 2'b10, 32'd0);
      idle(2);

      // Interleaved clients.
      send(5'd1, 2'b00, 32'd7);
      send(5'd2, 2'b00, 32'd9);
      send(5'd1, 2'b00, 32'd1);
      idle(2);

      // ADD -> CLEAR -> ADD chain on client 4.
      send(5'd4, 2'b00, 32'd20);
      send(5'd4, 2'b01, 32'd0);
      send(5'd4, 2'b00, 32'd3);
      send(5'd4, 2'b11, 32'd0);
      idle(2);

      // Overflow on client 0, forwarded back to back.
      send(5'd0, 2'b00, 32'hFFFF_FFF0);
      send(5'd0, 2'b00, 32'h20);
      send(5'd0, 2'b00, 32'h1);
      idle(2);
      send(5'd0, 2'b10, 32'd0);
      idle(3);

      // Random traffic, often on a few clients to stress forwarding.
      for (int i = 0; i < 400; i++) begin
         logic [CW-1:0] c;
         logic [31:0]   a;
         c = ($urandom_range(0, 1) == 0) ? CW'($urandom_range(0, 3)) : CW'($urandom_range(0, NC - 1));
         a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 1000));
         send(c, 2'($urandom_range(0, 3)), a);
         if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
      end
      idle(3);

      // Reset while three requests are in flight.
      send(5'd5, 2'b00, 32'd100);
      send(5'd6, 2'b00, 32'd200);
      in_valid     = 1'b1;
      in_client_id = 5'd5;
      in_op        = 2'b00;
      in_amount    = 32'd1;
      @(posedge clk);
      #1;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      exp_q.delete();
      for (int c = 0; c < NC; c++) model[c] = 32'd0;
      @(negedge clk);
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
      rst_n = 1'b1;
      init_wait();
      query_all();

      // Everything issued must have come back.
      idle(5);
      check("drain", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
